pll_lock_supervisor: RTL and testbench

- Supervises the system PLL from the 74.25 MHz bridge-side clock.
- Drives the PLL reset, synchronizes and debounces the PLL `locked` output, and releases the core reset only after a sustained lock.
- On loss of lock or timeout it re-resets the PLL and counts the event.
- Sits between the APF reset input and the PLL/core reset tree.

---
 rtl/pll_lock_supervisor_if.sv | 52 +++++
 rtl/pll_lock_supervisor.sv | 176 +++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_lock_supervisor_if.sv
// ---------------------------------------------------------------------------
// pll_lock_supervisor_if
//
// Purpose:
//   Groups the PLL-facing and reset-tree-facing signals of the PLL lock
//   supervisor so that the supervisor and its surroundings connect through a
//   single bundle.
//
// Signals:
//   pll_locked       PLL lock output, asynchronous to the supervisor clock
//   relock_req       one-cycle pulse asking for a fresh PLL reset cycle
//   pll_rst          active-high PLL reset
//   core_reset_n     active-low reset for PLL-clocked logic
//   pll_ready        high while the PLL is considered locked and stable
//   lock_loss_count  saturating count of lock losses and lock timeouts
//   state            debug view of the supervisor state (0..3)
//
// Modports:
//   master  the supervisor itself (drives the resets and status)
//   slave   the surroundings (drive the lock input and relock request)
// ---------------------------------------------------------------------------
interface pll_lock_supervisor_if;

  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic       core_reset_n;
  logic       pll_ready;
  logic [7:0] lock_loss_count;
  logic [1:0] state;

  modport master (
    input  pll_locked,
    input  relock_req,
    output pll_rst,
    output core_reset_n,
    output pll_ready,
    output lock_loss_count,
    output state
  );

  modport slave (
    output pll_locked,
    output relock_req,
    input  pll_rst,
    input  core_reset_n,
    input  pll_ready,
    input  lock_loss_count,
    input  state
  );

endinterface

// File: rtl/pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// pll_lock_supervisor
//
// Purpose:
//   Supervises the system PLL from the 74.25 MHz bridge-side clock. Pulses
//   the PLL reset, synchronizes the PLL lock flag, waits for a sustained lock
//   before releasing the core reset, and re-resets the PLL on loss of lock or
//   on a lock timeout, counting those events.
//
// Ports:
//   clk_74a  74.25 MHz free-running clock, all logic on the rising edge
//   reset_n  asynchronous active-low reset
//   bus      pll_lock_supervisor_if.master:
//              in  pll_locked, relock_req
//              out pll_rst, core_reset_n, pll_ready, lock_loss_count, state
//
// Parameters:
//   RST_CYCLES     cycles pll_rst is held high per PLL reset pulse (>= 1)
//   LOCK_TIMEOUT   cycles to wait for lock before retrying
//   STABLE_CYCLES  consecutive locked cycles required before RUN
//   CNT_W          width of the shared cycle counter
// ---------------------------------------------------------------------------
module pll_lock_supervisor #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 742500,
  parameter int unsigned STABLE_CYCLES = 4096,
  parameter int unsigned CNT_W         = 20
) (
  input  logic                  clk_74a,
  input  logic                  reset_n,
  pll_lock_supervisor_if.master bus
);

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  // Terminal counts: each state leaves on the cycle its counter reads N-1,
  // so the counter never needs to hold more than the largest of these.
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam longint unsigned  CNT_MAX      = (64'd1 << CNT_W) - 64'd1;

  // Refuse to elaborate with parameters the counter cannot represent, since
  // a wrapped counter would silently stretch or skip a phase.
  generate
    if (RST_CYCLES < 1 || LOCK_TIMEOUT < 1 || STABLE_CYCLES < 1) begin : g_bad_zero
      $error("pll_lock_supervisor: RST_CYCLES, LOCK_TIMEOUT and STABLE_CYCLES must be >= 1");
    end
    if (CNT_W < 1 || CNT_W > 32 ||
        longint'(RST_CYCLES)    > CNT_MAX ||
        longint'(LOCK_TIMEOUT)  > CNT_MAX ||
        longint'(STABLE_CYCLES) > CNT_MAX) begin : g_bad_width
      $error("pll_lock_supervisor: CNT_W too small for the configured cycle counts");
    end
  endgenerate

  state_t           fsm_state;
  logic [CNT_W-1:0] cnt;
  logic             lk_meta;
  logic             lk;
  logic             pll_rst_q;
  logic             core_reset_n_q;
  logic             pll_ready_q;
  logic [7:0]       loss_count;

  // Two-flop synchronizer for the PLL lock flag. pll_locked is asynchronous
  // to clk_74a, so nothing else in this block looks at it directly.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      lk_meta <= 1'b0;
      lk      <= 1'b0;
    end else begin
      lk_meta <= bus.pll_locked;
      lk      <= lk_meta;
    end
  end

  // Supervisor state machine. The reset outputs are flops loaded together
  // with the state transition, so pll_rst and core_reset_n change on the same
  // edge as the state and never glitch through decode logic. relock_req is
  // checked first because it overrides both lock loss and normal progress.
  // Dropping lock while still in STABLE is treated as acquisition jitter and
  // is not counted; only a timeout or a loss in RUN bumps the counter.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      fsm_state      <= PLL_RESET;
      cnt            <= '0;
      pll_rst_q      <= 1'b1;
      core_reset_n_q <= 1'b0;
      pll_ready_q    <= 1'b0;
      loss_count     <= 8'd0;
    end else if (bus.relock_req) begin
      fsm_state      <= PLL_RESET;
      cnt            <= '0;
      pll_rst_q      <= 1'b1;
      core_reset_n_q <= 1'b0;
      pll_ready_q    <= 1'b0;
    end else begin
      case (fsm_state)
        PLL_RESET: begin
          if (cnt == RST_LAST) begin
            fsm_state <= WAIT_LOCK;
            cnt       <= '0;
            pll_rst_q <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        WAIT_LOCK: begin
          if (lk) begin
            fsm_state <= STABLE;
            cnt       <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            fsm_state <= PLL_RESET;
            cnt       <= '0;
            pll_rst_q <= 1'b1;
            if (loss_count != 8'hFF) begin
              loss_count <= loss_count + 8'd1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        STABLE: begin
          if (!lk) begin
            fsm_state <= WAIT_LOCK;
            cnt       <= '0;
          end else if (cnt == STABLE_LAST) begin
            fsm_state      <= RUN;
            cnt            <= '0;
            core_reset_n_q <= 1'b1;
            pll_ready_q    <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RUN: begin
          if (!lk) begin
            fsm_state      <= PLL_RESET;
            cnt            <= '0;
            pll_rst_q      <= 1'b1;
            core_reset_n_q <= 1'b0;
            pll_ready_q    <= 1'b0;
            if (loss_count != 8'hFF) begin
              loss_count <= loss_count + 8'd1;
            end
          end
        end

        default: begin
          fsm_state      <= PLL_RESET;
          cnt            <= '0;
          pll_rst_q      <= 1'b1;
          core_reset_n_q <= 1'b0;
          pll_ready_q    <= 1'b0;
        end
      endcase
    end
  end

  // Present the registered state and outputs on the interface.
  assign bus.pll_rst         = pll_rst_q;
  assign bus.core_reset_n    = core_reset_n_q;
  assign bus.pll_ready       = pll_ready_q;
  assign bus.lock_loss_count = loss_count;
  assign bus.state           = fsm_state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_supervisor
//
// Purpose:
//   Directed self-checking bench for pll_lock_supervisor, run with shortened
//   timing parameters so that timeouts, re-acquisitions and counter
//   saturation fit in a short simulation.
// ---------------------------------------------------------------------------
module tb_pll_lock_supervisor;

  localparam int RST_CYCLES    = 16;
  localparam int LOCK_TIMEOUT  = 100;
  localparam int STABLE_CYCLES = 40;
  localparam int CNT_W         = 8;

  // From a pll_locked rising edge to core_reset_n rising: two synchronizer
  // flops, one edge to leave WAIT_LOCK, then STABLE_CYCLES in STABLE.
  localparam int ACQ_CYCLES = 2 + 1 + STABLE_CYCLES;

  logic clk_74a = 1'b0;
  logic reset_n;
  int   errors  = 0;
  int   checks  = 0;

  pll_lock_supervisor_if bus ();

  pll_lock_supervisor #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk_74a(clk_74a),
    .reset_n(reset_n),
    .bus    (bus.master)
  );

  // 100 MHz-ish bench clock; only cycle counts matter here.
  always #5 clk_74a = ~clk_74a;

  // Advance one clock and land 1 ns after the rising edge, where inputs are
  // driven and outputs are sampled.
  task automatic tick();
    @(posedge clk_74a);
    #1;
  endtask

  // Hold reset across a few edges and confirm every output sits at its reset value.
  task automatic test_reset();
    reset_n        = 1'b0;
    bus.pll_locked = 1'b0;
    bus.relock_req = 1'b0;
    repeat (3) tick();
    checks++; if (bus.state !== 2'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d expected 0", bus.state); end
    checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("[TB] FAIL reset_pll_rst: got %b expected 1", bus.pll_rst); end
    checks++; if (bus.core_reset_n !== 1'b0) begin errors++; $display("[TB] FAIL reset_core_reset_n: got %b expected 0", bus.core_reset_n); end
    checks++; if (bus.pll_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_pll_ready: got %b expected 0", bus.pll_ready); end
    checks++; if (bus.lock_loss_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.lock_loss_count); end
  endtask

  // With the PLL never locking, pll_rst re-pulses every RST+TIMEOUT cycles
  // and each retry bumps the loss counter.
  task automatic test_timeout();
    int n;
    int low_n;
    bit core_seen;
    reset_n = 1'b1;
    n = 0;
    do begin tick(); n++; end while (bus.pll_rst === 1'b1 && n < 100);
    checks++; if (n != RST_CYCLES) begin errors++; $display("[TB] FAIL timeout_first_rst_len: got %0d expected %0d", n, RST_CYCLES); end
    for (int r = 1; r <= 3; r++) begin
      if (r > 1) begin
        n = 0;
        do begin tick(); n++; end while (bus.pll_rst === 1'b1 && n < 100);
        checks++; if (n != RST_CYCLES) begin errors++; $display("[TB] FAIL timeout_rst_len_%0d: got %0d expected %0d", r, n, RST_CYCLES); end
      end
      low_n     = 0;
      core_seen = 1'b0;
      do begin
        tick();
        low_n++;
        if (bus.core_reset_n !== 1'b0 || bus.pll_ready !== 1'b0) core_seen = 1'b1;
      end while (bus.pll_rst === 1'b0 && low_n < 1000);
      checks++; if (low_n != LOCK_TIMEOUT) begin errors++; $display("[TB] FAIL timeout_wait_len_%0d: got %0d expected %0d", r, low_n, LOCK_TIMEOUT); end
      checks++; if (bus.lock_loss_count !== 8'(r)) begin errors++; $display("[TB] FAIL timeout_count_%0d: got %0d expected %0d", r, bus.lock_loss_count, r); end
      checks++; if (core_seen !== 1'b0) begin errors++; $display("[TB] FAIL timeout_core_held_%0d: got released expected held", r); end
    end
  endtask

  // Fresh reset, then a clean lock 20 cycles into WAIT_LOCK.
  task automatic test_clean_lock();
    int n;
    reset_n = 1'b0;
    tick();
    checks++; if (bus.lock_loss_count !== 8'd0) begin errors++; $display("[TB] FAIL clean_count_cleared: got %0d expected 0", bus.lock_loss_count); end
    reset_n = 1'b1;
    n = 0;
    do begin tick(); n++; end while (bus.pll_rst === 1'b1 && n < 100);
    checks++; if (n != RST_CYCLES) begin errors++; $display("[TB] FAIL clean_rst_len: got %0d expected %0d", n, RST_CYCLES); end
    checks++; if (bus.state !== 2'd1) begin errors++; $display("[TB] FAIL clean_wait_state: got %0d expected 1", bus.state); end
    repeat (20) tick();
    bus.pll_locked = 1'b1;
    n = 0;
    do begin tick(); n++; end while (bus.state === 2'd1 && n < 200);
    checks++; if (n != 3) begin errors++; $display("[TB] FAIL clean_to_stable: got %0d cycles expected 3", n); end
    checks++; if (bus.state !== 2'd2) begin errors++; $display("[TB] FAIL clean_stable_state: got %0d expected 2", bus.state); end
    while (bus.core_reset_n === 1'b0 && n < 200) begin tick(); n++; end
    checks++; if (n != ACQ_CYCLES) begin errors++; $display("[TB] FAIL clean_lock_to_release: got %0d expected %0d", n, ACQ_CYCLES); end
    checks++; if (bus.state !== 2'd3) begin errors++; $display("[TB] FAIL clean_run_state: got %0d expected 3", bus.state); end
    checks++; if (bus.pll_ready !== 1'b1) begin errors++; $display("[TB] FAIL clean_pll_ready: got %b expected 1", bus.pll_ready); end
    checks++; if (bus.lock_loss_count !== 8'd0) begin errors++; $display("[TB] FAIL clean_count: got %0d expected 0", bus.lock_loss_count); end
  endtask

  // relock_req in RUN: immediate PLL_RESET, no count change, full pulse,
  // then straight into STABLE because lock is still present.
  task automatic test_relock_in_run();
    int n;
    bus.relock_req = 1'b1;
    tick();
    bus.relock_req = 1'b0;
    checks++; if (bus.state !== 2'd0) begin errors++; $display("[TB] FAIL relock_run_state: got %0d expected 0", bus.state); end
    checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("[TB] FAIL relock_run_pll_rst: got %b expected 1", bus.pll_rst); end
    checks++; if (bus.core_reset_n !== 1'b0) begin errors++; $display("[TB] FAIL relock_run_core: got %b expected 0", bus.core_reset_n); end
    checks++; if (bus.lock_loss_count !== 8'd0) begin errors++; $display("[TB] FAIL relock_run_count: got %0d expected 0", bus.lock_loss_count); end
    n = 1;
    while (n < 100) begin
      tick();
      if (bus.pll_rst !== 1'b1) break;
      n++;
    end
    checks++; if (n != RST_CYCLES) begin errors++; $display("[TB] FAIL relock_run_rst_len: got %0d expected %0d", n, RST_CYCLES); end
    tick();
    checks++; if (bus.state !== 2'd2) begin errors++; $display("[TB] FAIL relock_run_restable: got %0d expected 2", bus.state); end
  endtask

  // A 3-cycle lock dropout midway through STABLE falls back to WAIT_LOCK
  // without a PLL reset or count, and the stable window restarts from zero.
  task automatic test_glitch();
    int n;
    bit rst_seen;
    rst_seen = 1'b0;
    repeat (20) tick();
    checks++; if (bus.state !== 2'd2) begin errors++; $display("[TB] FAIL glitch_pre_state: got %0d expected 2", bus.state); end
    bus.pll_locked = 1'b0;
    repeat (3) begin tick(); if (bus.pll_rst !== 1'b0) rst_seen = 1'b1; end
    checks++; if (bus.state !== 2'd1) begin errors++; $display("[TB] FAIL glitch_wait_state: got %0d expected 1", bus.state); end
    bus.pll_locked = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      if (bus.pll_rst !== 1'b0) rst_seen = 1'b1;
    end while (bus.core_reset_n === 1'b0 && n < 200);
    checks++; if (n != ACQ_CYCLES) begin errors++; $display("[TB] FAIL glitch_full_stable: got %0d expected %0d", n, ACQ_CYCLES); end
    checks++; if (rst_seen !== 1'b0) begin errors++; $display("[TB] FAIL glitch_no_pll_rst: got asserted expected never"); end
    checks++; if (bus.lock_loss_count !== 8'd0) begin errors++; $display("[TB] FAIL glitch_count: got %0d expected 0", bus.lock_loss_count); end
  endtask

  // relock_req at cycle 10 of PLL_RESET restarts the pulse: 10 + 16 cycles.
  task automatic test_relock_in_reset();
    int high;
    int n;
    bus.relock_req = 1'b1;
    tick();
    bus.relock_req = 1'b0;
    high = (bus.pll_rst === 1'b1) ? 1 : 0;
    repeat (9) begin tick(); if (bus.pll_rst === 1'b1) high++; end
    bus.relock_req = 1'b1;
    tick();
    bus.relock_req = 1'b0;
    if (bus.pll_rst === 1'b1) high++;
    n = 0;
    while (n < 100) begin
      tick();
      n++;
      if (bus.pll_rst !== 1'b1) break;
      high++;
    end
    checks++; if (high != 10 + RST_CYCLES) begin errors++; $display("[TB] FAIL relock_reset_rst_len: got %0d expected %0d", high, 10 + RST_CYCLES); end
    checks++; if (bus.lock_loss_count !== 8'd0) begin errors++; $display("[TB] FAIL relock_reset_count: got %0d expected 0", bus.lock_loss_count); end
    n = 0;
    while (bus.core_reset_n === 1'b0 && n < 200) begin tick(); n++; end
    checks++; if (bus.core_reset_n !== 1'b1) begin errors++; $display("[TB] FAIL relock_reset_reacquire: got %b expected 1", bus.core_reset_n); end
  endtask

  // Lock loss in RUN: resets asserted on the third edge after the drop,
  // count increments, and a clean re-acquisition follows.
  task automatic test_loss_in_run();
    int n;
    bus.pll_locked = 1'b0;
    repeat (2) tick();
    checks++; if (bus.core_reset_n !== 1'b1) begin errors++; $display("[TB] FAIL loss_early_core: got %b expected 1", bus.core_reset_n); end
    tick();
    checks++; if (bus.core_reset_n !== 1'b0) begin errors++; $display("[TB] FAIL loss_core_reset_n: got %b expected 0", bus.core_reset_n); end
    checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("[TB] FAIL loss_pll_rst: got %b expected 1", bus.pll_rst); end
    checks++; if (bus.pll_ready !== 1'b0) begin errors++; $display("[TB] FAIL loss_pll_ready: got %b expected 0", bus.pll_ready); end
    checks++; if (bus.lock_loss_count !== 8'd1) begin errors++; $display("[TB] FAIL loss_count: got %0d expected 1", bus.lock_loss_count); end
    repeat (30) tick();
    bus.pll_locked = 1'b1;
    n = 0;
    do begin tick(); n++; end while (bus.core_reset_n === 1'b0 && n < 200);
    checks++; if (n != ACQ_CYCLES) begin errors++; $display("[TB] FAIL loss_reacquire: got %0d expected %0d", n, ACQ_CYCLES); end
    checks++; if (bus.lock_loss_count !== 8'd1) begin errors++; $display("[TB] FAIL loss_count_after: got %0d expected 1", bus.lock_loss_count); end
  endtask

  // 300 more RUN losses drive the counter to 255 where it must hold.
  task automatic test_saturation();
    int exp_count;
    int n;
    exp_count = 1;
    for (int i = 0; i < 300; i++) begin
      bus.pll_locked = 1'b0;
      repeat (3) tick();
      bus.pll_locked = 1'b1;
      exp_count = (exp_count < 255) ? exp_count + 1 : 255;
      if (i == 252 || i == 253 || i == 299) begin
        checks++; if (bus.lock_loss_count !== 8'(exp_count)) begin errors++; $display("[TB] FAIL sat_count_%0d: got %0d expected %0d", i, bus.lock_loss_count, exp_count); end
      end
      n = 0;
      while (bus.core_reset_n === 1'b0 && n < 200) begin tick(); n++; end
      checks++; if (n >= 200) begin errors++; $display("[TB] FAIL sat_reacquire_%0d: got no release within %0d cycles expected release", i, n); break; end
    end
    checks++; if (bus.lock_loss_count !== 8'd255) begin errors++; $display("[TB] FAIL sat_final: got %0d expected 255", bus.lock_loss_count); end
  endtask

  // Asserting reset_n mid-STABLE takes effect between clock edges.
  task automatic test_reset_mid_stable();
    int n;
    bus.relock_req = 1'b1;
    tick();
    bus.relock_req = 1'b0;
    n = 0;
    while (bus.state !== 2'd2 && n < 100) begin tick(); n++; end
    repeat (10) tick();
    checks++; if (bus.state !== 2'd2) begin errors++; $display("[TB] FAIL midrst_pre_state: got %0d expected 2", bus.state); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.state !== 2'd0) begin errors++; $display("[TB] FAIL midrst_state: got %0d expected 0", bus.state); end
    checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("[TB] FAIL midrst_pll_rst: got %b expected 1", bus.pll_rst); end
    checks++; if (bus.core_reset_n !== 1'b0) begin errors++; $display("[TB] FAIL midrst_core: got %b expected 0", bus.core_reset_n); end
    checks++; if (bus.lock_loss_count !== 8'd0) begin errors++; $display("[TB] FAIL midrst_count: got %0d expected 0", bus.lock_loss_count); end
  endtask

  // Scenario sequence; each scenario leaves the DUT where the next expects it.
  initial begin
    test_reset();
    test_timeout();
    test_clean_lock();
    test_relock_in_run();
    test_glitch();
    test_relock_in_reset();
    test_loss_in_run();
    test_saturation();
    test_reset_mid_stable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Backstop in case a scenario stalls despite its own cycle bounds.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got no completion expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
